// File: rtl/strobe_stretch.sv
// strobe_stretch: turns a single-cycle strobe into a registered level pulse
// of programmable length. Optional retrigger. Strobes lost while busy are
// flagged and counted.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | out low, waiting for a strobe
//   ACTIVE | out high, count = remaining high cycles incl. current one
module strobe_stretch #(
  parameter int LEN_WIDTH  = 8,
  parameter int DROP_WIDTH = 8,
  parameter int RETRIGGER  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  clear_drops,
  output logic                  out,
  output logic                  done,
  output logic                  dropped,
  output logic [DROP_WIDTH-1:0] drop_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] count;
  logic                 last_cycle;
  logic                 accept;
  logic                 drop;
  logic                 len_zero;

  // Accept decode: idle, final high cycle (back-to-back), or always when retriggerable
  always_comb begin
    last_cycle = (state == ACTIVE) && (count == LEN_WIDTH'(1));
    accept     = in && ((state == IDLE) || last_cycle || (RETRIGGER != 0));
    drop       = in && !accept;
    len_zero   = (len == '0);
  end

  // Pulse FSM: load on accept, count down, issue done on the first low cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      out   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !len_zero) begin
            state <= ACTIVE;
            count <= len;
            out   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (accept && !len_zero) begin
            // reload keeps out high with no gap and no intermediate done
            count <= len;
          end else if (accept || last_cycle) begin
            // natural end, or a zero-length accepted strobe cutting the pulse short
            state <= IDLE;
            count <= '0;
            out   <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count - LEN_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          out   <= 1'b0;
        end
      endcase
    end
  end

  // Drop bookkeeping: one-cycle flag plus saturating counter; a clear coincident
  // with a drop leaves that drop counted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped    <= 1'b0;
      drop_count <= '0;
    end else begin
      dropped <= drop;
      if (clear_drops) begin
        drop_count <= drop ? DROP_WIDTH'(1) : '0;
      end else if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_strobe_stretch.sv
// Directed bench for strobe_stretch: three instances sharing one stimulus,
// non-retriggerable (u0), retriggerable (u1), and a 2-bit drop counter (u2).
module tb_strobe_stretch;

  logic       clk;
  logic       reset_n;
  logic       in;
  logic [7:0] len;
  logic       clear_drops;

  logic       out0, done0, dropped0;
  logic [7:0] dc0;
  logic       out1, done1, dropped1;
  logic [7:0] dc1;
  logic       out2, done2, dropped2;
  logic [1:0] dc2;

  int vectors;
  int miscompares;

  strobe_stretch #(.LEN_WIDTH(8), .DROP_WIDTH(8), .RETRIGGER(0)) u0 (
    .clk(clk), .reset_n(reset_n), .in(in), .len(len), .clear_drops(clear_drops),
    .out(out0), .done(done0), .dropped(dropped0), .drop_count(dc0));

  strobe_stretch #(.LEN_WIDTH(8), .DROP_WIDTH(8), .RETRIGGER(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in(in), .len(len), .clear_drops(clear_drops),
    .out(out1), .done(done1), .dropped(dropped1), .drop_count(dc1));

  strobe_stretch #(.LEN_WIDTH(8), .DROP_WIDTH(2), .RETRIGGER(0)) u2 (
    .clk(clk), .reset_n(reset_n), .in(in), .len(len), .clear_drops(clear_drops),
    .out(out2), .done(done2), .dropped(dropped2), .drop_count(dc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // called 1 ns after a rising edge; reset pulse ends well before the next edge
  task automatic do_reset;
    in          = 1'b0;
    len         = 8'd0;
    clear_drops = 1'b0;
    reset_n     = 1'b0;
    #3;
    reset_n     = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    in          = 1'b0;
    len         = 8'd0;
    clear_drops = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out0", out0, 0);      chk("rst done0", done0, 0);
    chk("rst drp0", dropped0, 0);  chk("rst dc0", dc0, 0);
    chk("rst out1", out1, 0);      chk("rst done1", done1, 0);
    chk("rst out2", out2, 0);      chk("rst dc2", dc2, 0);
    reset_n = 1'b1;
    tick();

    // single strobe, len=5 -> high k1..k5, done k6
    for (int k = 0; k < 8; k++) begin
      in  = (k == 0);
      len = 8'd5;
      chk($sformatf("t1 out0 k%0d", k), out0, (k >= 1 && k <= 5));
      chk($sformatf("t1 done0 k%0d", k), done0, (k == 6));
      chk($sformatf("t1 drp0 k%0d", k), dropped0, 0);
      chk($sformatf("t1 out1 k%0d", k), out1, (k >= 1 && k <= 5));
      chk($sformatf("t1 done1 k%0d", k), done1, (k == 6));
      tick();
    end

    // len=8 at k0, len=3 at k4: dropped without retrigger, reload with it
    do_reset();
    for (int k = 0; k < 11; k++) begin
      in  = (k == 0 || k == 4);
      len = (k == 4) ? 8'd3 : 8'd8;
      chk($sformatf("t2 out0 k%0d", k), out0, (k >= 1 && k <= 8));
      chk($sformatf("t2 drp0 k%0d", k), dropped0, (k == 5));
      chk($sformatf("t2 done0 k%0d", k), done0, (k == 9));
      chk($sformatf("t2 dc0 k%0d", k), dc0, (k >= 5));
      chk($sformatf("t2 dc2 k%0d", k), dc2, (k >= 5));
      chk($sformatf("t3 out1 k%0d", k), out1, (k >= 1 && k <= 7));
      chk($sformatf("t3 done1 k%0d", k), done1, (k == 8));
      chk($sformatf("t3 drp1 k%0d", k), dropped1, 0);
      chk($sformatf("t3 dc1 k%0d", k), dc1, 0);
      tick();
    end

    // back-to-back: len=4 at k0, len=2 on the last cycle k4 -> high k1..k6, one done k7
    do_reset();
    for (int k = 0; k < 9; k++) begin
      in  = (k == 0 || k == 4);
      len = (k == 4) ? 8'd2 : 8'd4;
      chk($sformatf("t4 out0 k%0d", k), out0, (k >= 1 && k <= 6));
      chk($sformatf("t4 done0 k%0d", k), done0, (k == 7));
      chk($sformatf("t4 drp0 k%0d", k), dropped0, 0);
      chk($sformatf("t4 out1 k%0d", k), out1, (k >= 1 && k <= 6));
      chk($sformatf("t4 done1 k%0d", k), done1, (k == 7));
      tick();
    end

    // held level = repeated strobes; saturation of 2-bit counter; clear vs drop
    do_reset();
    for (int k = 0; k < 12; k++) begin
      in          = (k == 0) || (k >= 2 && k <= 6) || (k == 8);
      len         = 8'd10;
      clear_drops = (k == 8) || (k == 10);
      chk($sformatf("t5 dc2 k%0d", k), dc2,
          (k < 3) ? 0 : (k == 3) ? 1 : (k == 4) ? 2 : (k <= 8) ? 3 : (k <= 10) ? 1 : 0);
      chk($sformatf("t5 dc0 k%0d", k), dc0,
          (k < 3) ? 0 : (k <= 7) ? (k - 2) : (k == 8) ? 5 : (k <= 10) ? 1 : 0);
      chk($sformatf("t5 drp0 k%0d", k), dropped0, ((k >= 3 && k <= 7) || k == 9));
      chk($sformatf("t5 out0 k%0d", k), out0, (k >= 1 && k <= 10));
      chk($sformatf("t5 done0 k%0d", k), done0, (k == 11));
      chk($sformatf("t5 out1 k%0d", k), out1, (k >= 1));
      chk($sformatf("t5 dc1 k%0d", k), dc1, 0);
      tick();
    end
    clear_drops = 1'b0;

    // async reset mid-pulse, then a len=0 strobe in IDLE
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in  = (k == 0);
      len = 8'd10;
      chk($sformatf("t6 out0 k%0d", k), out0, (k >= 1));
      tick();
    end
    in = 1'b0;
    chk("t6 out0 k3 pre", out0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 out0 async", out0, 0);
    chk("t6 out1 async", out1, 0);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      in  = (k == 5);
      len = (k == 5) ? 8'd0 : 8'd10;
      chk($sformatf("t6 out0 post k%0d", k), out0, 0);
      chk($sformatf("t6 done0 post k%0d", k), done0, 0);
      chk($sformatf("t6 drp0 post k%0d", k), dropped0, 0);
      chk($sformatf("t6 out1 post k%0d", k), out1, 0);
      chk($sformatf("t6 done1 post k%0d", k), done1, 0);
      tick();
    end

    // len=0 strobe while active: ends the pulse under retrigger, dropped otherwise
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in  = (k == 0 || k == 2);
      len = (k == 2) ? 8'd0 : 8'd5;
      chk($sformatf("t7 out1 k%0d", k), out1, (k >= 1 && k <= 2));
      chk($sformatf("t7 done1 k%0d", k), done1, (k == 3));
      chk($sformatf("t7 drp1 k%0d", k), dropped1, 0);
      chk($sformatf("t7 out0 k%0d", k), out0, (k >= 1 && k <= 5));
      chk($sformatf("t7 drp0 k%0d", k), dropped0, (k == 3));
      chk($sformatf("t7 done0 k%0d", k), done0, (k == 6));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
